// File: rtl/logic_unit_seq_if.sv
// Handshake and operand/result bus for logic_unit_seq.
// Port zero exists only when LOGIC_UNIT_SEQ_ZERO_FLAG_EN is defined.
interface logic_unit_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Result;
  logic             busy;
  logic             done;
`ifdef LOGIC_UNIT_SEQ_ZERO_FLAG_EN
  logic             zero;

  modport master (output start, op, A, B, input Result, busy, done, zero);
  modport slave  (input start, op, A, B, output Result, busy, done, zero);
`else
  modport master (output start, op, A, B, input Result, busy, done);
  modport slave  (input start, op, A, B, output Result, busy, done);
`endif
endinterface

// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit (AND/OR/XOR/NOR), CHUNK bits per clock, low chunk first.
// Optional registered zero flag under LOGIC_UNIT_SEQ_ZERO_FLAG_EN.
module logic_unit_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            reset,
  logic_unit_seq_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    idx_r;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] result_r;
  logic             busy_r;
  logic             done_r;
  logic             zero_r;

  logic [CHUNK-1:0] a_chunk_s;
  logic [CHUNK-1:0] b_chunk_s;
  logic [CHUNK-1:0] chunk_s;
  logic [WIDTH-1:0] next_result_s;

  function automatic logic [CHUNK-1:0] op_chunk(
    input logic [1:0]       op,
    input logic [CHUNK-1:0] a,
    input logic [CHUNK-1:0] b
  );
    case (op)
      2'b00:   op_chunk = a & b;
      2'b01:   op_chunk = a | b;
      2'b10:   op_chunk = a ^ b;
      2'b11:   op_chunk = ~(a | b);
      default: op_chunk = '0;
    endcase
  endfunction

  // Select the active operand chunk so a single CHUNK-wide gate slice is reused.
  always_comb begin
    a_chunk_s = '0;
    b_chunk_s = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_r == CW'(i)) begin
        a_chunk_s = a_r[i*CHUNK +: CHUNK];
        b_chunk_s = b_r[i*CHUNK +: CHUNK];
      end else begin
        a_chunk_s = a_chunk_s;
        b_chunk_s = b_chunk_s;
      end
    end
  end

  assign chunk_s = op_chunk(op_r, a_chunk_s, b_chunk_s);

  // Merge the freshly computed chunk into the in-place result.
  always_comb begin
    next_result_s = result_r;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_r == CW'(i)) begin
        next_result_s[i*CHUNK +: CHUNK] = chunk_s;
      end else begin
        next_result_s[i*CHUNK +: CHUNK] = result_r[i*CHUNK +: CHUNK];
      end
    end
  end

  // Control FSM with registered status outputs; reset abandons any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      idx_r    <= '0;
      op_r     <= 2'b00;
      a_r      <= '0;
      b_r      <= '0;
      result_r <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      zero_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            a_r     <= bus.A;
            b_r     <= bus.B;
            op_r    <= bus.op;
            idx_r   <= '0;
            zero_r  <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          result_r <= next_result_s;
          if (idx_r == LAST_IDX) begin
            zero_r  <= (next_result_s == '0);
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            idx_r   <= idx_r + CW'(1);
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.Result = result_r;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
`ifdef LOGIC_UNIT_SEQ_ZERO_FLAG_EN
  assign bus.zero   = zero_r;
`else
  logic unused_zero_s;
  assign unused_zero_s = zero_r;
`endif
endmodule

// File: tb/tb_logic_unit_seq.sv
// Directed self-checking bench for logic_unit_seq (32/8 instance plus a 16/16 instance).
// Zero-flag checks are compiled in when LOGIC_UNIT_SEQ_ZERO_FLAG_EN is defined.
module tb_logic_unit_seq;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  logic_unit_seq_if #(.WIDTH(32)) bus32 ();
  logic_unit_seq_if #(.WIDTH(16)) bus16 ();

  logic_unit_seq #(.WIDTH(32), .CHUNK(8))  u_dut   (.clk(clk), .reset(reset), .bus(bus32));
  logic_unit_seq #(.WIDTH(16), .CHUNK(16)) u_dut16 (.clk(clk), .reset(reset), .bus(bus16));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic start32(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    @(negedge clk);
    bus32.A     = a;
    bus32.B     = b;
    bus32.op    = op;
    bus32.start = 1'b1;
    @(posedge clk);
    #1;
    bus32.start = 1'b0;
  endtask

  // edges = number of edges after the accepting edge at which done was seen
  task automatic wait_done32(output int edges);
    bit found = 1'b0;
    edges = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus32.done === 1'b1) begin
        found = 1'b1;
        edges = k;
        break;
      end
    end
    if (!found) check_val("done_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] tbl_a   [4] = '{32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
  logic [31:0] tbl_b   [4] = '{32'h0F0F0F0F, 32'h0F0F0F0F, 32'h0F0F0F0F, 32'h0F0F0F0F};
  logic [1:0]  tbl_op  [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
  logic [31:0] tbl_exp [4] = '{32'h1F3F5F7F, 32'h1D3B5977, 32'hE0C0A080, 32'h02040608};

  initial begin
    int edges;
    int done_seen;
    reset       = 1'b1;
    bus32.start = 1'b0; bus32.op = 2'b00; bus32.A = 32'd0; bus32.B = 32'd0;
    bus16.start = 1'b0; bus16.op = 2'b00; bus16.A = 16'd0; bus16.B = 16'd0;
    repeat (2) @(negedge clk);
    check_val("rst_result", bus32.Result, 32'h0);
    check_val("rst_busy", 32'(bus32.busy), 32'd0);
    check_val("rst_done", 32'(bus32.done), 32'd0);
    check_val("rst16_result", 32'(bus16.Result), 32'h0);
`ifdef LOGIC_UNIT_SEQ_ZERO_FLAG_EN
    check_val("rst_zero", 32'(bus32.zero), 32'd0);
`endif
    reset = 1'b0;

    // Reset mid-operation: reset sampled at edge 2
    start32(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00);
    @(negedge clk);
    @(negedge clk);
    check_val("midop_partial", bus32.Result, 32'h000000FF);
    reset = 1'b1;
    @(negedge clk);
    check_val("midop_busy", 32'(bus32.busy), 32'd0);
    check_val("midop_done", 32'(bus32.done), 32'd0);
    check_val("midop_result", bus32.Result, 32'h0);
    reset = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus32.done === 1'b1) done_seen++;
    end
    check_val("midop_no_done", 32'(done_seen), 32'd0);

    // AND latency and one-cycle done pulse
    start32(32'hF0F0F0F0, 32'hFF00FF00, 2'b00);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_val($sformatf("and_busy_e%0d", k), 32'(bus32.busy), (k < 4) ? 32'd1 : 32'd0);
      check_val($sformatf("and_done_e%0d", k), 32'(bus32.done), (k == 4) ? 32'd1 : 32'd0);
      if (k == 1) check_val("and_chunk0", 32'(bus32.Result[7:0]), 32'h00);
      if (k == 2) check_val("and_chunk01", 32'(bus32.Result[15:0]), 32'hF000);
      if (k == 4) check_val("and_result", bus32.Result, 32'hF000F000);
    end

    // All four operations
    for (int t = 0; t < 4; t++) begin
      start32(tbl_a[t], tbl_b[t], tbl_op[t]);
      wait_done32(edges);
      check_val($sformatf("ops_latency_%0d", t), 32'(edges), 32'd4);
      check_val($sformatf("ops_result_%0d", t), bus32.Result, tbl_exp[t]);
      @(negedge clk);
      check_val($sformatf("ops_pulse_%0d", t), 32'(bus32.done), 32'd0);
    end

    // start held high through RUN and DONE with new operands
    @(negedge clk);
    bus32.A = 32'h12345678; bus32.B = 32'h0F0F0F0F; bus32.op = 2'b10; bus32.start = 1'b1;
    @(posedge clk);
    #1;
    bus32.A = 32'hFFFFFFFF; bus32.B = 32'h00000000; bus32.op = 2'b01;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 4) begin
        check_val("ign_done", 32'(bus32.done), 32'd1);
        check_val("ign_result", bus32.Result, 32'h1D3B5977);
      end
      if (k == 5) check_val("ign_idle_busy", 32'(bus32.busy), 32'd0);
      if (k == 6) check_val("ign_second_accept", 32'(bus32.busy), 32'd1);
    end
    bus32.start = 1'b0;
    wait_done32(edges);
    check_val("ign_second_result", bus32.Result, 32'hFFFFFFFF);

    // WIDTH == CHUNK: single RUN cycle
    @(negedge clk);
    bus16.A = 16'hAAAA; bus16.B = 16'h5555; bus16.op = 2'b10; bus16.start = 1'b1;
    @(posedge clk);
    #1;
    bus16.start = 1'b0;
    @(negedge clk);
    check_val("w16_busy", 32'(bus16.busy), 32'd1);
    check_val("w16_done_early", 32'(bus16.done), 32'd0);
    @(negedge clk);
    check_val("w16_done", 32'(bus16.done), 32'd1);
    check_val("w16_result", 32'(bus16.Result), 32'h0000FFFF);
    @(negedge clk);
    check_val("w16_pulse", 32'(bus16.done), 32'd0);

`ifdef LOGIC_UNIT_SEQ_ZERO_FLAG_EN
    start32(32'hAAAAAAAA, 32'h55555555, 2'b00);
    wait_done32(edges);
    check_val("zf_and_result", bus32.Result, 32'h0);
    check_val("zf_and_zero", 32'(bus32.zero), 32'd1);
    @(negedge clk);
    check_val("zf_hold", 32'(bus32.zero), 32'd1);
    start32(32'hAAAAAAAA, 32'h55555555, 2'b01);
    @(negedge clk);
    check_val("zf_clear_on_start", 32'(bus32.zero), 32'd0);
    wait_done32(edges);
    check_val("zf_or_result", bus32.Result, 32'hFFFFFFFF);
    check_val("zf_or_zero", 32'(bus32.zero), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
